pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the MIPS core.
- Sits directly downstream of the PCSrc mux: consumes NextPC and produces PC / PC_plus_4, which feed back into that mux's PC_plus_4 input.
- Drives a request/grant/response handshake to instruction memory.
- Presents one fetched instruction at a time to decode with a valid/ready handshake.

---
 rtl/pc_fetch_unit_pkg.sv | 16 +
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit_pc_reg.sv | 23 ++
 rtl/pc_fetch_unit.sv | 139 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } fetch_state_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/grant/response bus.
// master: fetch unit side; slave: instruction memory side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// 32-bit program counter with load enable; loaded values are word-aligned.
module pc_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // PC register; low two address bits are silently cleared on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load_en) begin
      q <= d & PC_ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Optional WAIT-state timeout enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            NextPC,
  input  logic                   instr_ready,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus_4,
  output logic [31:0]            Instruction,
  output logic                   instr_valid,
  pc_fetch_unit_if.master        imem,
  output logic                   fetch_error
);

  fetch_state_t state_q, state_d;
  logic         pc_load;
  logic         instr_load;
  logic [31:0]  instr_d;
  logic         tmo_fire;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .d       (NextPC),
    .q       (PC)
  );

  assign PC_plus_4      = PC + PC_INCR;
  assign imem.imem_addr = PC;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        fetch_error_q;

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle; a response
  // arriving on that same cycle still wins.
  assign tmo_fire = (state_q == WAIT) && !imem.imem_rvalid &&
                    (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter: counts while staying in WAIT, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == WAIT && state_d == WAIT) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky fetch error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_error_q <= 1'b0;
    end else if (tmo_fire) begin
      fetch_error_q <= 1'b1;
    end
  end

  assign fetch_error = fetch_error_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_fire       = 1'b0;
  assign fetch_error    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and capture/load strobes.
  always_comb begin
    state_d       = state_q;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    pc_load       = 1'b0;
    instr_load    = 1'b0;
    instr_d       = imem.imem_rdata;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_gnt) begin
          if (imem.imem_rvalid) begin
            instr_load = 1'b1;
            state_d    = VALID;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_load = 1'b1;
          state_d    = VALID;
        end else if (tmo_fire) begin
          instr_load = 1'b1;
          instr_d    = NOP_INSTR;
          state_d    = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_load = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction register: written only on an accepted response or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Instruction <= NOP_INSTR;
    end else if (instr_load) begin
      Instruction <= instr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit; FETCH_TIMEOUT_EN selects the timeout scenario.
module tb_pc_fetch_unit;
  import mips_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_ready = 1'b0;
  logic [31:0] NextPC = '0;
  logic [31:0] PC, PC_plus_4, Instruction;
  logic        instr_valid, fetch_error;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  exp_t        exp_q[$];

  pc_fetch_unit_if imem_bus();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .NextPC      (NextPC),
    .instr_ready (instr_ready),
    .PC          (PC),
    .PC_plus_4   (PC_plus_4),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .imem        (imem_bus),
    .fetch_error (fetch_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side stimulus: waits for a request, grants after gnt_dly cycles
  // (stray rvalid meanwhile), responds rv_dly cycles after the grant and
  // pushes the expected (pc, instr) pair. Returns at the negedge after the
  // response edge.
  task automatic mem_serve(input int unsigned gnt_dly, input int unsigned rv_dly,
                           input logic [31:0] data, input logic [31:0] exp_pc,
                           output int unsigned req_cycles, output logic [31:0] first_addr,
                           output bit addr_stable, output bit seen);
    req_cycles = 0; addr_stable = 1'b1; seen = 1'b0; first_addr = '0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (imem_bus.imem_req) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) return;
    first_addr = imem_bus.imem_addr;
    for (int unsigned i = 0; i < gnt_dly; i++) begin
      if (imem_bus.imem_req) req_cycles++;
      if (imem_bus.imem_addr != first_addr) addr_stable = 1'b0;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = $urandom;
      @(negedge clk);
    end
    if (imem_bus.imem_req) req_cycles++;
    if (imem_bus.imem_addr != first_addr) addr_stable = 1'b0;
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = (rv_dly == 0);
    imem_bus.imem_rdata  = (rv_dly == 0) ? data : $urandom;
    if (rv_dly == 0) exp_q.push_back('{pc: exp_pc, instr: data});
    @(negedge clk);
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = $urandom;
    if (rv_dly > 0) begin
      for (int unsigned i = 1; i < rv_dly; i++) begin
        if (imem_bus.imem_req) req_cycles++;
        @(negedge clk);
      end
      if (imem_bus.imem_req) req_cycles++;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = data;
      exp_q.push_back('{pc: exp_pc, instr: data});
      @(negedge clk);
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = $urandom;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    n_checks++; if (PC_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", PC_plus_4, 32'h4); end
    n_checks++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", Instruction, 32'h0); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
    n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_error); end
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_basic();
    int unsigned rc; logic [31:0] fa; bit st, sn; exp_t e;
    mem_serve(0, 0, 32'h2008_0005, 32'h0, rc, fa, st, sn);
    n_checks++; if (sn !== 1'b1) begin n_fail++; $display("FAIL basic_req_seen: got %b want 1", sn); end
    n_checks++; if (fa !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h want %h", fa, 32'h0); end
    n_checks++; if (cyc - rel_cyc !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", cyc - rel_cyc); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL basic_sb: got empty queue want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL basic_instr: got %h want %h", Instruction, e.instr); end
      n_checks++; if (PC !== e.pc) begin n_fail++; $display("FAIL basic_pc: got %h want %h", PC, e.pc); end
    end
    instr_ready = 1'b1; NextPC = 32'h4;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (PC !== 32'h4) begin n_fail++; $display("FAIL basic_commit_pc: got %h want %h", PC, 32'h4); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", instr_valid); end
    n_checks++; if (imem_bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_addr: got %h want %h", imem_bus.imem_addr, 32'h4); end
  endtask

  task automatic test_delayed();
    int unsigned rc; logic [31:0] fa; bit st, sn; exp_t e;
    mem_serve(3, 2, 32'h8C09_0010, 32'h4, rc, fa, st, sn);
    n_checks++; if (fa !== 32'h4) begin n_fail++; $display("FAIL delay_addr: got %h want %h", fa, 32'h4); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL delay_addr_stable: got %b want 1", st); end
    n_checks++; if (rc !== 4) begin n_fail++; $display("FAIL delay_req_cycles: got %0d want 4", rc); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL delay_valid: got %b want 1", instr_valid); end
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL delay_sb: got empty queue want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL delay_instr: got %h want %h", Instruction, e.instr); end
      n_checks++; if (PC !== e.pc) begin n_fail++; $display("FAIL delay_pc: got %h want %h", PC, e.pc); end
    end
    instr_ready = 1'b1; NextPC = 32'h100;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (PC !== 32'h100) begin n_fail++; $display("FAIL delay_commit_pc: got %h want %h", PC, 32'h100); end
  endtask

  task automatic test_hold();
    int unsigned rc; logic [31:0] fa; bit st, sn; exp_t e;
    mem_serve(1, 1, 32'hAC0A_0020, 32'h100, rc, fa, st, sn);
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL hold_sb: got empty queue want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL hold_instr: got %h want %h", Instruction, e.instr); end
    end
    for (int unsigned i = 0; i < 5; i++) begin
      NextPC = $urandom;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = $urandom;
      @(negedge clk);
      n_checks++; if (PC !== 32'h100) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want %h", i, PC, 32'h100); end
      n_checks++; if (Instruction !== 32'hAC0A_0020) begin n_fail++; $display("FAIL hold_instr[%0d]: got %h want %h", i, Instruction, 32'hAC0A_0020); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, instr_valid); end
    end
    imem_bus.imem_rvalid = 1'b0;
    instr_ready = 1'b1; NextPC = 32'h0000_0043;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (PC !== 32'h40) begin n_fail++; $display("FAIL hold_align_pc: got %h want %h", PC, 32'h40); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_drop: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_mid();
    int unsigned rc; logic [31:0] fa; bit st, sn; exp_t e;
    sn = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (imem_bus.imem_req) begin sn = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (sn !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_seen: got %b want 1", sn); end
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait_req: got %b want 0", imem_bus.imem_req); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc: got %h want %h", PC, 32'h0); end
    n_checks++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr: got %h want %h", Instruction, 32'h0); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", instr_valid); end
    n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", imem_bus.imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    mem_serve(0, 0, 32'h2402_0007, 32'h0, rc, fa, st, sn);
    n_checks++; if (fa !== 32'h0) begin n_fail++; $display("FAIL rstmid_refetch_addr: got %h want %h", fa, 32'h0); end
    n_checks++; if (cyc - rel_cyc !== 2) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 2", cyc - rel_cyc); end
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL rstmid_sb: got empty queue want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL rstmid_instr2: got %h want %h", Instruction, e.instr); end
    end
    instr_ready = 1'b1; NextPC = 32'hFFFF_FFFF;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rstmid_commit_pc: got %h want %h", PC, 32'hFFFF_FFFC); end
  endtask

  task automatic test_wrap();
    int unsigned rc; logic [31:0] fa; bit st, sn; exp_t e;
    n_checks++; if (PC_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want %h", PC_plus_4, 32'h0); end
    mem_serve(0, 1, 32'h0800_0000, 32'hFFFF_FFFC, rc, fa, st, sn);
    n_checks++; if (fa !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want %h", fa, 32'hFFFF_FFFC); end
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL wrap_sb: got empty queue want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", Instruction, e.instr); end
      n_checks++; if (PC !== e.pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", PC, e.pc); end
    end
    instr_ready = 1'b1; NextPC = PC_plus_4;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_commit_pc: got %h want %h", PC, 32'h0); end
    n_checks++; if (PC_plus_4 !== 32'h4) begin n_fail++; $display("FAIL wrap_commit_pc4: got %h want %h", PC_plus_4, 32'h4); end
  endtask

  task automatic test_back_to_back();
    int unsigned rc, t0; logic [31:0] fa, pc_exp; bit st, sn; exp_t e;
    pc_exp = 32'h0;
    for (int unsigned k = 0; k < 3; k++) begin
      t0 = cyc;
      mem_serve(0, 0, 32'h1000_0000 + k, pc_exp, rc, fa, st, sn);
      if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL b2b_sb[%0d]: got empty queue want 1 entry", k); end
      else begin
        e = exp_q.pop_front();
        n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, Instruction, e.instr); end
        n_checks++; if (PC !== e.pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, PC, e.pc); end
      end
      pc_exp = pc_exp + 32'h10;
      instr_ready = 1'b1; NextPC = pc_exp;
      @(negedge clk);
      instr_ready = 1'b0;
      n_checks++; if (cyc - t0 !== 2) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want 2", k, cyc - t0); end
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned cnt; bit sn;
    sn = 1'b0; cnt = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (imem_bus.imem_req) begin sn = 1'b1; break; end
      @(negedge clk);
    end
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    for (int unsigned i = 0; i < 200; i++) begin
      if (instr_valid) break;
      cnt++;
      @(negedge clk);
    end
    n_checks++; if (cnt !== 64) begin n_fail++; $display("FAIL tmo_cycles: got %0d want 64", cnt); end
    n_checks++; if (fetch_error !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", fetch_error); end
    n_checks++; if (Instruction !== NOP_INSTR) begin n_fail++; $display("FAIL tmo_instr: got %h want %h", Instruction, NOP_INSTR); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_valid: got %b want 1", instr_valid); end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    n_checks++; if (Instruction !== NOP_INSTR) begin n_fail++; $display("FAIL tmo_late_rvalid: got %h want %h", Instruction, NOP_INSTR); end
    instr_ready = 1'b1; NextPC = 32'h200;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (fetch_error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", fetch_error); end
    n_checks++; if (PC !== 32'h200) begin n_fail++; $display("FAIL tmo_commit_pc: got %h want %h", PC, 32'h200); end
  endtask
`else
  task automatic test_long_wait();
    bit sn; exp_t e;
    sn = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (imem_bus.imem_req) begin sn = 1'b1; break; end
      @(negedge clk);
    end
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    repeat (80) @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL longwait_valid: got %b want 0", instr_valid); end
    n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL longwait_err: got %b want 0", fetch_error); end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h3C01_1234;
    exp_q.push_back('{pc: 32'h30, instr: 32'h3C01_1234});
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL longwait_valid2: got %b want 1", instr_valid); end
    e = exp_q.pop_front();
    n_checks++; if (Instruction !== e.instr) begin n_fail++; $display("FAIL longwait_instr: got %h want %h", Instruction, e.instr); end
    n_checks++; if (PC !== e.pc) begin n_fail++; $display("FAIL longwait_pc: got %h want %h", PC, e.pc); end
    instr_ready = 1'b1; NextPC = 32'h200;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask
`endif

  initial begin
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    test_reset();
    test_basic();
    test_delayed();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
